// File: rtl/goertzel_bin_sched.sv
// Sequencer for the shared Goertzel iteration core: waits for the angle block, then issues
// NF ITER ops per accepted sample and NF FINAL ops after N_SAMP samples, then pulses done.
module goertzel_bin_sched #(
    parameter int NF     = 11,
    parameter int N_SAMP = 1000,
    parameter int DW     = 16,
    parameter int IW     = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    output logic                 angel_en,
    input  logic                 angel_ready,
    input  logic                 start,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic signed [DW-1:0] s_data,
    output logic                 core_valid,
    input  logic                 core_ready,
    output logic                 core_op,
    output logic        [IW-1:0] core_bin,
    output logic                 core_first,
    output logic signed [DW-1:0] core_sample,
    output logic                 busy,
    output logic                 done,
    output logic           [2:0] dbg_state
);

    localparam int SW = (N_SAMP > 1) ? $clog2(N_SAMP) : 1;
    localparam logic [IW-1:0] LAST_BIN  = IW'(NF - 1);
    localparam logic [SW-1:0] LAST_SAMP = SW'(N_SAMP - 1);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WAIT_S = 3'd2,
        ST_ITER   = 3'd3,
        ST_FINAL  = 3'd4,
        ST_DONE   = 3'd5
    } state_t;

    state_t               state_q, state_d;
    logic        [SW-1:0] samp_cnt_q, samp_cnt_d;
    logic        [IW-1:0] bin_cnt_q, bin_cnt_d;
    logic signed [DW-1:0] sample_q, sample_d;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_INIT;
            samp_cnt_q <= '0;
            bin_cnt_q  <= '0;
            sample_q   <= '0;
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            bin_cnt_q  <= bin_cnt_d;
            sample_q   <= sample_d;
        end
    end

    // Valid/ready: a transfer happens on a clock edge where both are high. Op fields come
    // only from registers, so they hold while core_valid && !core_ready, and core_valid
    // stays high until the op is taken. s_ready is high only while waiting for a sample.
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        bin_cnt_d  = bin_cnt_q;
        sample_d   = sample_q;
        case (state_q)
            ST_INIT: begin
                if (angel_ready) state_d = ST_IDLE;
            end
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_WAIT_S;
                    samp_cnt_d = '0;
                    bin_cnt_d  = '0;
                end
            end
            ST_WAIT_S: begin
                if (s_valid) begin
                    sample_d = s_data;
                    state_d  = ST_ITER;
                end
            end
            ST_ITER: begin
                if (core_ready) begin
                    if (bin_cnt_q == LAST_BIN) begin
                        bin_cnt_d = '0;
                        if (samp_cnt_q == LAST_SAMP) begin
                            samp_cnt_d = '0;
                            sample_d   = '0;
                            state_d    = ST_FINAL;
                        end else begin
                            samp_cnt_d = samp_cnt_q + SW'(1);
                            state_d    = ST_WAIT_S;
                        end
                    end else begin
                        bin_cnt_d = bin_cnt_q + IW'(1);
                    end
                end
            end
            ST_FINAL: begin
                if (core_ready) begin
                    if (bin_cnt_q == LAST_BIN) begin
                        bin_cnt_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        bin_cnt_d = bin_cnt_q + IW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    assign angel_en    = (state_q == ST_INIT);
    assign s_ready     = (state_q == ST_WAIT_S);
    assign core_valid  = (state_q == ST_ITER) || (state_q == ST_FINAL);
    assign core_op     = (state_q == ST_FINAL);
    assign core_bin    = bin_cnt_q;
    assign core_first  = (state_q == ST_ITER) && (samp_cnt_q == '0);
    assign core_sample = sample_q;
    assign busy        = (state_q == ST_WAIT_S) || (state_q == ST_ITER) || (state_q == ST_FINAL);
    assign done        = (state_q == ST_DONE);
    assign dbg_state   = state_q;

endmodule
